// File: rtl/park_pkg.sv
// park_pkg: shared state encoding, city codes, sizes and one-hot helpers
// for the smart-park session controller.
package park_pkg;
  localparam int N_CITY = 3;
  localparam int N_SPOT = 9;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CITY    = 3'd1,
    S_SPOT    = 3'd2,
    S_CONFIRM = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_t;
  localparam logic [1:0] CITY_NYC = 2'd0;
  localparam logic [1:0] CITY_TOR = 2'd1;
  localparam logic [1:0] CITY_WAT = 2'd2;
  function automatic logic onehot3_valid(input logic [2:0] v);
    return (v != 3'd0) && ((v & (v - 3'd1)) == 3'd0);
  endfunction
  // switch order is MSB-first: 100 selects city 0
  function automatic logic [1:0] onehot3_decode(input logic [2:0] v);
    return v[2] ? CITY_NYC : v[1] ? CITY_TOR : CITY_WAT;
  endfunction
  function automatic logic onehot9_valid(input logic [8:0] v);
    return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
  endfunction
  function automatic logic [3:0] onehot9_decode(input logic [8:0] v);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < N_SPOT; i++) if (v[i]) d = 4'(i);
    return d;
  endfunction
  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < N_SPOT; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/park_occ_table.sv
// park_occ_table: per-city spot occupancy bitmap with a single write port
// and row/bit lookup at the same city/spot address.
module park_occ_table
  import park_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_set,
  input  logic [1:0]        city,
  input  logic [3:0]        spot,
  output logic [N_SPOT-1:0] row,
  output logic              occupied
);
  logic [N_CITY-1:0][N_SPOT-1:0] occ;
  always_ff @(posedge clk or posedge reset)
    if (reset) occ <= '0;
    else if (wr_en) occ[city][spot] <= wr_set;
  assign row      = occ[city];
  assign occupied = occ[city][spot];
endmodule

// File: rtl/park_session_ctrl.sv
// park_session_ctrl: front-panel session FSM (city -> spot -> confirm) with
// inactivity timeout and message hold; owns the occupancy table.
module park_session_ctrl
  import park_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 15,
  parameter int MSG_TICKS     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       key_go,
  input  logic       key_back,
  input  logic       mode_release,
  input  logic [2:0] city_sw,
  input  logic [8:0] spot_sw,
  output logic [1:0] city,
  output logic [3:0] spot,
  output logic [8:0] occ_view,
  output logic [3:0] free_count,
  output logic [2:0] state_out,
  output logic       result_ok,
  output logic       result_err
);
  localparam int CW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_TICKS - 1);
  localparam logic [CW-1:0] MSG_LAST = CW'(MSG_TICKS - 1);
  state_t          state, state_nxt;
  logic [1:0]      city_nxt;
  logic [3:0]      spot_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            wr_en, wr_set, occupied, key, expire, msg_state;
  park_occ_table u_occ (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_set   (wr_set),
    .city     (city),
    .spot     (spot),
    .row      (occ_view),
    .occupied (occupied)
  );
  assign key       = key_go | key_back;
  assign expire    = tick && cnt == TO_LAST;
  assign msg_state = state == S_DONE || state == S_ERR;
  // any key (even an ignored one) beats a coincident terminal tick
  always_comb begin
    state_nxt = state;
    city_nxt  = city;
    spot_nxt  = spot;
    wr_en     = 1'b0;
    wr_set    = 1'b0;
    case (state)
      S_IDLE: if (key_go && !key_back) state_nxt = S_CITY;
      S_CITY:
        if (key_back) state_nxt = S_IDLE;
        else if (key_go) begin
          if (onehot3_valid(city_sw)) begin
            city_nxt  = onehot3_decode(city_sw);
            state_nxt = S_SPOT;
          end
        end else if (expire) state_nxt = S_IDLE;
      S_SPOT:
        if (key_back) state_nxt = S_CITY;
        else if (key_go) begin
          if (onehot9_valid(spot_sw)) begin
            spot_nxt  = onehot9_decode(spot_sw);
            state_nxt = (!mode_release && free_count == 4'd0) ? S_ERR : S_CONFIRM;
          end
        end else if (expire) state_nxt = S_IDLE;
      S_CONFIRM:
        if (key_back) state_nxt = S_SPOT;
        else if (key_go) begin
          wr_en     = mode_release == occupied;
          wr_set    = !mode_release;
          state_nxt = (mode_release == occupied) ? S_DONE : S_ERR;
        end else if (expire) state_nxt = S_IDLE;
      S_DONE, S_ERR: if (tick && cnt == MSG_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    cnt_nxt = (state_nxt != state || (key && !msg_state)) ? '0 :
              (tick && state != S_IDLE) ? cnt + 1'b1 : cnt;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      city  <= CITY_NYC;
      spot  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      city  <= city_nxt;
      spot  <= spot_nxt;
      cnt   <= cnt_nxt;
    end
  assign free_count = 4'(N_SPOT) - popcount9(occ_view);
  assign state_out  = state;
  assign result_ok  = state == S_DONE;
  assign result_err = state == S_ERR;
endmodule

// File: tb/tb_park_session_ctrl.sv
// tb_park_session_ctrl: scenario tasks push expected snapshots into a
// scoreboard queue and pop/compare them after each DUT clock edge.
module tb_park_session_ctrl;
  logic clk = 1'b0, reset = 1'b1, tick = 1'b0, key_go = 1'b0, key_back = 1'b0, mode_release = 1'b0;
  logic [2:0] city_sw = 3'b000;
  logic [8:0] spot_sw = 9'd0;
  logic [1:0] city;
  logic [3:0] spot, free_count;
  logic [8:0] occ_view;
  logic [2:0] state_out;
  logic result_ok, result_err;
  int checks = 0, failures = 0;
  logic [23:0] sb[$];
  logic [23:0] e;
  logic [2:0][8:0] m_occ = '0;
  wire [23:0] obs = {state_out, result_ok, result_err, city, spot, occ_view, free_count};

  park_session_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .key_go(key_go), .key_back(key_back),
    .mode_release(mode_release), .city_sw(city_sw), .spot_sw(spot_sw), .city(city),
    .spot(spot), .occ_view(occ_view), .free_count(free_count), .state_out(state_out),
    .result_ok(result_ok), .result_err(result_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  function automatic logic [23:0] x(input logic [2:0] st, input logic [1:0] c, input logic [3:0] s);
    logic [8:0] r;
    r = m_occ[c];
    return {st, st == 3'd4, st == 3'd5, c, s, r, 4'(9 - $countones(r))};
  endfunction

  task automatic cyc(input logic g, input logic b, input logic t);
    @(negedge clk);
    key_go = g; key_back = b; tick = t;
    @(posedge clk);
    #1;
    key_go = 1'b0; key_back = 1'b0; tick = 1'b0;
  endtask

  task automatic go_k;
    cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic back_k;
    cyc(1'b0, 1'b1, 1'b0);
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(x(3'd0, 2'd0, 4'd0));
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_state obs=%h exp=%h", obs, e); end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_park;
    city_sw = 3'b010; spot_sw = 9'b000010000; mode_release = 1'b0;
    sb.push_back(x(3'd1, 2'd0, 4'd0)); go_k;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL park_enter_city obs=%h exp=%h", obs, e); end
    sb.push_back(x(3'd2, 2'd1, 4'd0)); go_k;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL park_latch_city obs=%h exp=%h", obs, e); end
    sb.push_back(x(3'd3, 2'd1, 4'd4)); go_k;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL park_latch_spot obs=%h exp=%h", obs, e); end
    m_occ[1][4] = 1'b1;
    sb.push_back(x(3'd4, 2'd1, 4'd4)); go_k;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL park_done obs=%h exp=%h", obs, e); end
    sb.push_back(x(3'd4, 2'd1, 4'd4)); ticks(2);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL park_done_hold obs=%h exp=%h", obs, e); end
    sb.push_back(x(3'd0, 2'd1, 4'd4)); ticks(1);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL park_done_exit obs=%h exp=%h", obs, e); end
  endtask

  task automatic test_err_release;
    go_k; go_k; go_k;
    sb.push_back(x(3'd5, 2'd1, 4'd4)); go_k;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL park_occupied_err obs=%h exp=%h", obs, e); end
    sb.push_back(x(3'd0, 2'd1, 4'd4)); ticks(3);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL err_exit obs=%h exp=%h", obs, e); end
    mode_release = 1'b1;
    go_k; go_k;
    sb.push_back(x(3'd3, 2'd1, 4'd4)); go_k;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL release_confirm obs=%h exp=%h", obs, e); end
    m_occ[1][4] = 1'b0;
    sb.push_back(x(3'd4, 2'd1, 4'd4)); go_k;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL release_done obs=%h exp=%h", obs, e); end
    ticks(3);
    go_k; go_k; go_k;
    sb.push_back(x(3'd5, 2'd1, 4'd4)); go_k;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL release_free_err obs=%h exp=%h", obs, e); end
    ticks(3);
  endtask

  task automatic test_full;
    mode_release = 1'b0; city_sw = 3'b001;
    for (int i = 0; i < 9; i++) begin
      spot_sw = 9'(1) << i;
      go_k; go_k; go_k;
      m_occ[2][i] = 1'b1;
      sb.push_back(x(3'd4, 2'd2, 4'(i))); go_k;
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL fill_done_%0d obs=%h exp=%h", i, obs, e); end
      ticks(3);
    end
    go_k;
    sb.push_back(x(3'd2, 2'd2, 4'd8)); go_k;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL full_spot_state obs=%h exp=%h", obs, e); end
    spot_sw = 9'b100000000;
    sb.push_back(x(3'd5, 2'd2, 4'd8)); go_k;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL full_city_err obs=%h exp=%h", obs, e); end
    sb.push_back(x(3'd0, 2'd2, 4'd8)); ticks(3);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL full_err_exit obs=%h exp=%h", obs, e); end
  endtask

  task automatic test_invalid;
    go_k;
    city_sw = 3'b110;
    sb.push_back(x(3'd1, 2'd2, 4'd8)); go_k;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL city_two_hot obs=%h exp=%h", obs, e); end
    city_sw = 3'b000;
    sb.push_back(x(3'd1, 2'd2, 4'd8)); go_k;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL city_zero obs=%h exp=%h", obs, e); end
    city_sw = 3'b100; go_k;
    spot_sw = 9'd0;
    sb.push_back(x(3'd2, 2'd0, 4'd8)); go_k;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL spot_zero obs=%h exp=%h", obs, e); end
    spot_sw = 9'b000000011;
    sb.push_back(x(3'd2, 2'd0, 4'd8)); go_k;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL spot_two_hot obs=%h exp=%h", obs, e); end
    sb.push_back(x(3'd1, 2'd0, 4'd8)); cyc(1'b1, 1'b1, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL go_back_together obs=%h exp=%h", obs, e); end
    go_k;
    spot_sw = 9'b000001000; go_k;
    sb.push_back(x(3'd2, 2'd0, 4'd3)); back_k;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL confirm_back obs=%h exp=%h", obs, e); end
    back_k;
    sb.push_back(x(3'd0, 2'd0, 4'd3)); back_k;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL city_back obs=%h exp=%h", obs, e); end
  endtask

  task automatic test_timeout;
    mode_release = 1'b1; city_sw = 3'b001; spot_sw = 9'b000100000;
    go_k; go_k; go_k;
    sb.push_back(x(3'd3, 2'd2, 4'd5)); ticks(14);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL timeout_tick14 obs=%h exp=%h", obs, e); end
    sb.push_back(x(3'd0, 2'd2, 4'd5)); ticks(1);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL timeout_tick15 obs=%h exp=%h", obs, e); end
    go_k; go_k;
    ticks(14);
    spot_sw = 9'd0;
    sb.push_back(x(3'd2, 2'd2, 4'd5)); cyc(1'b1, 1'b0, 1'b1);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL key_on_terminal_tick obs=%h exp=%h", obs, e); end
    sb.push_back(x(3'd2, 2'd2, 4'd5)); ticks(14);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL counter_cleared obs=%h exp=%h", obs, e); end
    sb.push_back(x(3'd0, 2'd2, 4'd5)); ticks(1);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL timeout_after_clear obs=%h exp=%h", obs, e); end
  endtask

  task automatic test_async_reset;
    spot_sw = 9'b000000001;
    go_k; go_k;
    sb.push_back(x(3'd3, 2'd2, 4'd0)); go_k;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL pre_reset_confirm obs=%h exp=%h", obs, e); end
    #2 reset = 1'b1;
    m_occ = '0;
    sb.push_back(x(3'd0, 2'd0, 4'd0));
    #1;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL async_reset obs=%h exp=%h", obs, e); end
    @(negedge clk) reset = 1'b0;
    go_k;
    sb.push_back(x(3'd2, 2'd2, 4'd0)); go_k;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL table_cleared obs=%h exp=%h", obs, e); end
  endtask

  initial begin
    test_reset;
    test_park;
    test_err_release;
    test_full;
    test_invalid;
    test_timeout;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/park_session_ctrl.md
Name: park_session_ctrl

Overview:
- Session sequencer for the smart-park front panel.
- Walks the user through city selection, spot selection and confirm, in either park or release mode.
- Owns the per-city spot occupancy table: 3 cities x 9 spots.
- Drives display/LED outputs and returns to idle on completion or inactivity timeout.

Parameters:
N_CITY, 3, number of cities (codes 0..2)
N_SPOT, 9, spots per city (indices 0..8)
TIMEOUT_TICKS, 15, inactivity ticks in CITY/SPOT/CONFIRM before abort to IDLE
MSG_TICKS, 3, ticks DONE/ERR is held before returning to IDLE

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state including occupancy
tick  in  1  one-cycle slow time-base pulse
key_go  in  1  one-cycle pulse, debounced and edge-detected upstream
key_back  in  1  one-cycle pulse, same conditioning as key_go
mode_release  in  1  level; 0 = park, 1 = release
city_sw  in  3  one-hot: 100 -> city 0, 010 -> city 1, 001 -> city 2
spot_sw  in  9  one-hot: bit i -> spot i
city  out  2  latched city code
spot  out  4  latched spot index
occ_view  out  9  occupancy bitmap of the latched city
free_count  out  4  9 minus popcount(occ_view)
state_out  out  3  current state encoding
result_ok  out  1  high while in DONE
result_err  out  1  high while in ERR

Behaviour:
- State encodings: IDLE=0, CITY=1, SPOT=2, CONFIRM=3, DONE=4, ERR=5.
- Reset values:
  - state IDLE; city 0; spot 0.
  - occupancy 27'b0, so occ_view = 0 and free_count = 9.
  - result_ok and result_err 0; tick counter 0.
- All transitions take effect at the clock edge on which the key pulse is sampled. Outputs are registered or derived from registers; no combinational path from inputs to outputs.
- IDLE: key_go -> CITY.
- CITY:
  - key_go with valid one-hot city_sw -> latch city, go to SPOT.
  - key_go with invalid city_sw (not exactly one bit set) -> ignored.
  - key_back -> IDLE.
- SPOT:
  - key_go with valid one-hot spot_sw -> latch spot, go to CONFIRM.
  - Exception: park mode and free_count==0 -> ERR instead of CONFIRM.
  - key_go with invalid spot_sw -> ignored.
  - key_back -> CITY; latched city is kept.
- CONFIRM, key_go (mode_release sampled here):
  - park, spot free -> set bit, go to DONE.
  - park, spot occupied -> go to ERR.
  - release, spot occupied -> clear bit, go to DONE.
  - release, spot free -> go to ERR.
  - key_back -> SPOT.
- Occupancy is updated on the same edge that enters DONE. ERR never modifies occupancy.
- key_go and key_back asserted together: key_back wins.
- Timeout:
  - Tick counter clears on any key pulse and on every state change.
  - Counter increments on tick in CITY, SPOT and CONFIRM.
  - Counter reaching TIMEOUT_TICKS -> IDLE; city, spot and occupancy unchanged.
  - A key pulse coincident with the terminal tick takes priority over the timeout.
- DONE/ERR:
  - Keys ignored.
  - After MSG_TICKS ticks -> IDLE.
  - result_ok/result_err are asserted for exactly the cycles state_out==4 or 5.
- occ_view tracks the latched city. It updates the cycle after latching or the cycle after the occupancy write.
- Asynchronous reset mid-session aborts immediately and clears the occupancy table. No other path clears occupancy.
- Spot indices above 8 are unreachable, because spot is only latched from a valid one-hot.

Decomposition:
- Package park_pkg holds:
  - state encoding constants;
  - city code constants CITY_NYC=0, CITY_TOR=1, CITY_WAT=2;
  - N_CITY and N_SPOT;
  - functions onehot3_valid/decode and onehot9_valid/decode;
  - popcount9.
- Sub-module park_occ_table:
  - 27-bit bitmap;
  - inputs: set/clear strobe with city/spot address;
  - outputs: 9-bit row read for the selected city and a single-bit occupied lookup;
  - uses the same async reset.
- The FSM and tick counter stay in park_session_ctrl.

Test Plan:
- Reset, then key_go; city_sw=010 + go; spot_sw=bit4 + go; park + go -> DONE with result_ok=1, city=1, spot=4, occ_view=000010000, free_count=8; IDLE after 3 ticks.
- Repeat the same city/spot park -> ERR with result_err=1, occupancy unchanged; then the release flow on the same spot -> DONE, occ_view=0, free_count=9.
- Fill all 9 spots of city 2, start a new park session on city 2 -> key_go in SPOT goes to ERR; free_count=0.
- Invalid inputs: city_sw=110 or spot_sw=0 with key_go -> state unchanged. key_go+key_back together in SPOT -> CITY.
- Enter CONFIRM, then 15 ticks with no keys -> IDLE, occupancy unchanged. A key pulse on tick 15 -> timeout suppressed and counter cleared.
- Assert reset in CONFIRM with occupancy nonzero -> state_out=0, occ_view=0, free_count=9, result outputs low, with no clock edge required.
